// File: rtl/bram_readback_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_readback_reader
// Brief    : Walks a wrapping BRAM address range and streams the words out on
//            valid/ready with a last flag; a credit-limited FIFO absorbs the
//            RAM read latency. Optional macro BRAM_READBACK_PARITY_EN adds
//            m_parity (XOR reduction of m_data) stored per FIFO entry.
// Revision : 1.0 - initial release
// ============================================================================
module bram_readback_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
`ifdef BRAM_READBACK_PARITY_EN
    ,
    output logic              m_parity
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = PTR_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W:0]       r_remaining;
    logic                  r_done;

    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [RD_LATENCY-1:0] r_pipe_last;

    logic [DATA_W-1:0]     r_mem      [FIFO_DEPTH];
    logic                  r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [SUM_W-1:0]      w_inflight;
    logic [SUM_W-1:0]      w_occupancy;
    logic                  w_start_ok;
    logic                  w_start_zero;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_hs;

    // Tokens still in the RAM pipe hold a FIFO slot in reserve (credit).
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + SUM_W'(r_pipe_vld[i]);
        end
    end

    assign w_occupancy  = SUM_W'(r_count) + w_inflight;
    assign w_start_ok   = (r_state == S_IDLE) && start && (length != '0);
    assign w_start_zero = (r_state == S_IDLE) && start && (length == '0);
    assign w_issue      = (r_state == S_RUN) && (w_occupancy < SUM_W'(FIFO_DEPTH));
    assign w_last_issue = w_issue && (r_remaining == (ADDR_W+1)'(1));
    assign w_push       = r_pipe_vld[RD_LATENCY-1];
    assign w_pop        = m_valid && m_ready;
    assign w_last_hs    = w_pop && m_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_last_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_start_zero || ((r_state == S_DRAIN) && w_last_hs);
            if (w_start_ok) begin
                r_addr      <= base_addr;
                r_remaining <= length;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
        end else begin
            r_pipe_vld[0]  <= w_issue;
            r_pipe_last[0] <= w_last_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]      <= bram_rd_data;
            r_mem_last[r_wr_ptr] <= r_pipe_last[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head outputs are gated so an empty FIFO shows the reset values.
    assign m_valid      = (r_count != '0);
    assign m_data       = m_valid ? r_mem[r_rd_ptr] : '0;
    assign m_last       = m_valid ? r_mem_last[r_rd_ptr] : 1'b0;
    assign done         = r_done;
    assign bram_rd_addr = r_addr;

`ifdef BRAM_READBACK_PARITY_EN
    logic r_mem_par [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_par[r_wr_ptr] <= ^bram_rd_data;
        end
    end

    assign m_parity = m_valid ? r_mem_par[r_rd_ptr] : 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/bram_readback_reader.md
# bram_readback_reader

Read-side sequencer for a 1 KB block RAM configured in 32-bit read mode (256 × 32). On a start command it walks a contiguous, wrapping address range on the RAM read port and delivers the words on a valid/ready stream with a last flag. It sits between the fabric BRAM tile and any consumer such as a debug readback or DMA path. Credit-based buffering absorbs RAM read latency so no word is ever dropped under back-pressure.

## Interface
- `ADDR_W`, default 8: RAM word-address width; range is 2^ADDR_W words.
- `DATA_W`, default 32: RAM read data width.
- `RD_LATENCY`, default 1: RAM read latency in cycles, 1 = output register bypassed, 2 = registered. Must match the RAM's bypass setting. Other values are illegal.
- `FIFO_DEPTH`, default 4: output buffer entries, power of two, ≥ RD_LATENCY+2.
- `clk` in 1: single clock for the block and the RAM.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: begin a transfer. Sampled only in IDLE.
- `base_addr` in ADDR_W: first word address, captured at start.
- `length` in ADDR_W+1: number of words, 0..256, captured at start.
- `busy` out 1: high from the cycle after start is accepted until done.
- `done` out 1: one-cycle pulse at transfer completion.
- `bram_rd_addr` out ADDR_W: registered RAM read address.
- `bram_rd_data` in DATA_W: RAM read data.
- `m_data` out DATA_W: stream data.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `m_last` out 1: marks the final word of the transfer.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE → RUN when `start`=1 and `length`≠0.
  - IDLE → IDLE with `done` pulsed the next cycle when `start`=1 and `length`=0. `busy` stays 0.
  - RUN → DRAIN on the edge that issues the final read.
  - DRAIN → IDLE on the edge where the last word is accepted (`m_valid`&`m_ready`&`m_last`). `done`=1 in the following cycle.
- **Issue rule:** in RUN, a read is issued in a cycle only when fifo_count + inflight < FIFO_DEPTH, where fifo_count is before that cycle's pop.
  - An issue drives `bram_rd_addr` for that cycle, shifts a valid token (with a last bit) into a RD_LATENCY-deep pipe, and increments the address modulo 2^ADDR_W. Example: base 0xFE, length 4 reads FE, FF, 00, 01.
  - A remaining-count register decrements on each issue. The last bit is set on the issue where remaining = 1.
- **Data capture:** a token exiting the pipe writes `bram_rd_data` and its last bit into the FIFO. The FIFO head drives `m_data`/`m_last`. `m_valid` = FIFO non-empty.
- **Stream rules:**
  - `m_data`/`m_last` are held stable while `m_valid`=1 and `m_ready`=0.
  - `m_valid` never drops without a handshake.
- `start` is ignored while `busy`=1.
- A push and a pop in the same cycle leave the count unchanged. Overflow is impossible by construction; verification must assert it.
- **Reset:** `resetn` low at any time, including mid-transfer, immediately clears the FSM to IDLE, empties the FIFO, and clears the pipe tokens. In-flight data is discarded.
- **Reset values:** `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `bram_rd_addr`=0.

## Timing
- Start accepted at edge 0. Cycle 1: `busy`=1, first address on `bram_rd_addr`.
- Data for an address presented in cycle t is valid on `bram_rd_data` in cycle t+RD_LATENCY and pushed at the end of that cycle.
- First `m_valid`=1 in cycle 2+RD_LATENCY.
- Throughput is 1 word/cycle with `m_ready` held high.
- With `m_ready` low, issue stalls within FIFO_DEPTH words.
- `done` follows the last handshake by exactly one cycle. `busy` falls in the same cycle `done` is high.
- A new `start` is accepted in the cycle `done` is high.

## Configuration
- **`BRAM_READBACK_PARITY_EN` defined:** adds output `m_parity` (1 bit) = even parity (XOR reduction) of `m_data`. It is stored alongside each FIFO entry and is 0 in reset.
- **Not defined:** the port and its storage are absent. All other behaviour is identical.

## Test plan
- RD_LATENCY=1, base 0x10, length 8, `m_ready`=1, RAM[a]=a·0x01010101 → words 0x10101010..0x17171717 on consecutive cycles. First `m_valid` in cycle 3, `m_last` on the 8th word, `done` one cycle later.
- RD_LATENCY=2, base 0xFE, length 4 → addresses FE, FF, 00, 01 in order. Data matches; first `m_valid` in cycle 4.
- Length 256 with `m_ready` toggled randomly, 30% low → all 256 words delivered exactly once, in order. Data stable while stalled. FIFO never overflows.
- `length`=0 start → `done` pulses next cycle. `busy` stays 0 and no `bram_rd_addr` activity.
- `start` pulsed while busy mid-transfer → ignored; the original transfer completes unchanged.
- `resetn` asserted after 3 of 8 words delivered → all outputs return to reset values the same cycle. A subsequent start of length 2 delivers exactly 2 fresh words.
